// File: rtl/alu_requester.sv
// Initiator side of the ALU start/finish handshake: accepts requests, issues one
// start pulse per legal op, waits for a qualified finish or a timeout, and returns a response.
module alu_requester #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned FINISH_BLANK = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_sign,
  output logic [1:0]       rsp_status,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_start,
  input  logic             alu_finish,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_sign,
  output logic             busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned BW = (FINISH_BLANK > 0) ? $clog2(FINISH_BLANK + 1) : 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUIET = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0]    blank_q, blank_d;
  logic             qualified;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             sign_q, sign_d;
  logic [1:0]       status_q, status_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  // Next-state and next-register values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    c_d       = c_q;
    sign_d    = sign_q;
    status_d  = status_q;
    cnt_inc   = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    qualified = (blank_q >= BW'(FINISH_BLANK));

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          a_d   = req_a;
          b_d   = req_b;
          op_d  = req_opcode;
          cnt_d = '0;
          if (req_opcode >= OP_FIRST_ILLEGAL) begin
            state_d  = S_RESP;
            c_d      = '0;
            sign_d   = 1'b0;
            status_d = ST_ILLEGAL;
          end else begin
            state_d = S_QUIET;
          end
        end
      end
      // A finish left over from the previous op must drop before we start
      S_QUIET: begin
        cnt_d = cnt_inc;
        if (!alu_finish) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = cnt_inc;
        blank_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (!qualified) blank_d = blank_q + BW'(1);
        // A qualified finish takes priority over a coincident timeout
        if (qualified && alu_finish) begin
          state_d  = S_RESP;
          c_d      = alu_c;
          sign_d   = alu_sign;
          status_d = ST_OK;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d  = S_RESP;
          c_d      = '0;
          sign_d   = 1'b0;
          status_d = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    start_d     = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      blank_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      c_q         <= '0;
      sign_q      <= 1'b0;
      status_q    <= ST_OK;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      c_q         <= c_d;
      sign_q      <= sign_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_c      = c_q;
  assign rsp_sign   = sign_q;
  assign rsp_status = status_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_start  = start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_requester.sv
// Self-checking bench for alu_requester: directed vector table, multi-cycle corner
// sequences and randomized requests against a rule-based response model.
`timescale 1ns/1ps
module tb_alu_requester;
  localparam int unsigned WIDTH        = 32;
  localparam int unsigned TIMEOUT      = 64;
  localparam int unsigned FINISH_BLANK = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_c;
  logic             rsp_sign;
  logic [1:0]       rsp_status;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_opcode;
  logic             alu_start, alu_finish;
  logic [WIDTH-1:0] alu_c;
  logic             alu_sign;
  logic             busy;

  alu_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .FINISH_BLANK(FINISH_BLANK)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_sign(rsp_sign), .rsp_status(rsp_status),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_finish(alu_finish), .alu_c(alu_c), .alu_sign(alu_sign), .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_acc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference ALU function; sign is reported for arithmetic ops only
  function automatic logic [WIDTH:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] c;
    case (op)
      4'd0:  c = a | b;
      4'd1:  c = a ^ b;
      4'd2:  c = a & b;
      4'd3:  c = ~a;
      4'd4:  c = a;
      4'd5:  c = b;
      4'd6:  c = ~(a & b);
      4'd7:  c = ~(a | b);
      4'd8:  c = a + b;
      4'd9:  c = a - b;
      4'd10: c = b - a;
      4'd11: c = a + WIDTH'(1);
      default: c = '0;
    endcase
    return {op[3] & c[WIDTH-1], c};
  endfunction

  // Behavioural ALU: finish pulse alu_delay cycles after start (0 = never)
  int   alu_delay = 0;
  int   cd = 0;
  logic mfin = 1'b0;
  logic force_fin = 1'b0;
  assign alu_finish = mfin | force_fin;

  always @(posedge clock) begin
    if (reset) begin
      cd   <= 0;
      mfin <= 1'b0;
    end else if (alu_start) begin
      cd   <= alu_delay;
      mfin <= 1'b0;
    end else if (cd != 0) begin
      cd   <= cd - 1;
      mfin <= (cd == 1);
      if (cd == 1) {alu_sign, alu_c} <= alu_fn(alu_opcode, alu_a, alu_b);
    end else begin
      mfin <= 1'b0;
    end
  end

  // Protocol monitor: start counting, back-to-back pulses, operand stability while busy
  int   start_cnt = 0;
  int   b2b = 0;
  int   stab_err = 0;
  logic prev_start = 1'b0;
  logic [3:0]       exp_op = '0;
  logic [WIDTH-1:0] exp_a = '0, exp_b = '0;

  always @(posedge clock) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    if (alu_start && prev_start) b2b <= b2b + 1;
    prev_start <= alu_start;
    if (!reset && busy && (alu_opcode !== exp_op || alu_a !== exp_a || alu_b !== exp_b))
      stab_err <= stab_err + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response rules, stated from the requester's contract
  function automatic logic [1:0] model_status(input logic [3:0] op, input int d);
    if (op >= 4'hC) return 2'b01;
    if (d >= int'(FINISH_BLANK) && d <= int'(TIMEOUT) - 2) return 2'b00;
    return 2'b10;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input int d);
    case (model_status(op, d))
      2'b01:   return 1;
      2'b00:   return d + 4;
      default: return int'(TIMEOUT) + 2;
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_before_send", 64'(req_ready), 64'd1);
    exp_op = op; exp_a = a; exp_b = b;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    @(negedge clock);
    req_valid = 1'b0; req_opcode = 4'($urandom); req_a = $urandom; req_b = $urandom;
    t_acc = cyc;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic expect_rsp(input string name, input logic [WIDTH-1:0] c, input logic sign,
                            input logic [1:0] st, input int lat);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (lat >= 0) check({name, "_latency"}, 64'(cyc - t_acc + 1), 64'(lat));
    check({name, "_rsp_c"}, 64'(rsp_c), 64'(c));
    check({name, "_rsp_sign"}, 64'(rsp_sign), 64'(sign));
    check({name, "_rsp_status"}, 64'(rsp_status), 64'(st));
  endtask

  task automatic consume(input string name, input int hold);
    logic [WIDTH+2:0] snap;
    snap = {rsp_sign, rsp_status, rsp_c};
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({name, "_hold"}, 64'({rsp_valid, req_ready, busy, rsp_sign, rsp_status, rsp_c}),
            64'({3'b101, snap}));
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({name, "_consumed"}, 64'({rsp_valid, req_ready, busy}), 64'(3'b010));
  endtask

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b;
    int               delay;
    logic [WIDTH-1:0] c;
    logic             sign;
    logic [1:0]       status;
  } vec_t;

  task automatic run_vec(input string name, input vec_t v, input int hold);
    int s0;
    s0 = start_cnt;
    alu_delay = v.delay;
    send(v.op, v.a, v.b);
    expect_rsp(name, v.c, v.sign, v.status, model_lat(v.op, v.delay));
    consume(name, hold);
    check({name, "_start_count"}, 64'(start_cnt - s0), (v.status == 2'b01) ? 64'd0 : 64'd1);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t rv;
    logic [WIDTH:0] r;
    int n, s0, seen;

    tbl[0]  = '{4'h2, 32'hF0F0_0000, 32'hFF00_FF00, 3, 32'hF000_0000, 1'b0, 2'b00};
    tbl[1]  = '{4'hC, 32'd1, 32'd2, 3, 32'd0, 1'b0, 2'b01};
    tbl[2]  = '{4'h8, 32'd9, 32'd9, 0, 32'd0, 1'b0, 2'b10};
    tbl[3]  = '{4'h8, 32'd5, 32'd7, 2, 32'd12, 1'b0, 2'b00};
    tbl[4]  = '{4'h9, 32'd5, 32'd7, 4, 32'hFFFF_FFFE, 1'b1, 2'b00};
    tbl[5]  = '{4'hF, 32'd3, 32'd4, 2, 32'd0, 1'b0, 2'b01};
    tbl[6]  = '{4'h0, 32'h1234_0000, 32'h0000_5678, 2, 32'h1234_5678, 1'b0, 2'b00};
    tbl[7]  = '{4'h1, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'd0, 1'b0, 2'b10};
    tbl[8]  = '{4'hB, 32'hFFFF_FFFF, 32'd0, 5, 32'd0, 1'b0, 2'b00};
    tbl[9]  = '{4'hA, 32'd3, 32'd1, 2, 32'hFFFF_FFFE, 1'b1, 2'b00};
    tbl[10] = '{4'h7, 32'd0, 32'd0, 6, 32'hFFFF_FFFF, 1'b0, 2'b00};
    tbl[11] = '{4'h3, 32'h0F0F_0F0F, 32'd0, 7, 32'hF0F0_F0F0, 1'b0, 2'b00};

    reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", 64'({req_ready, rsp_valid, alu_start, busy, rsp_status, alu_opcode}),
          64'({4'b1000, 2'b00, 4'h0}));
    check("reset_operands", {alu_a, alu_b}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), tbl[i], (i == 2) ? 10 : i % 3);

    // Backpressure with a pending request held off until the handshake
    alu_delay = 2;
    send(4'h8, 32'd100, 32'd23);
    expect_rsp("bp", 32'd123, 1'b0, 2'b00, 6);
    req_valid = 1'b1; req_opcode = 4'h9; req_a = 32'd50; req_b = 32'd8;
    consume("bp", 10);
    exp_op = 4'h9; exp_a = 32'd50; exp_b = 32'd8;
    @(negedge clock);
    req_valid = 1'b0;
    t_acc = cyc;
    check("bp_pending_accepted", 64'({busy, alu_opcode}), 64'({1'b1, 4'h9}));
    expect_rsp("bp_next", 32'd42, 1'b0, 2'b00, 6);
    consume("bp_next", 0);

    // Stale finish held high at acceptance
    s0 = start_cnt;
    alu_delay = 2;
    force_fin = 1'b1;
    send(4'h2, 32'hFFFF_0000, 32'h00FF_FF00);
    for (int i = 0; i < 4; i++) begin
      check("stale_no_start", 64'({alu_start, busy}), 64'(2'b01));
      @(negedge clock);
    end
    force_fin = 1'b0;
    @(negedge clock);
    check("stale_start_after_fall", 64'(alu_start), 64'd1);
    expect_rsp("stale", 32'h00FF_0000, 1'b0, 2'b00, -1);
    consume("stale", 1);
    check("stale_start_count", 64'(start_cnt - s0), 64'd1);

    // Finish glitch inside the blanking window is ignored
    alu_delay = 4;
    send(4'h8, 32'd10, 32'd20);
    n = 0;
    while (!alu_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("glitch_saw_start", 64'(alu_start), 64'd1);
    @(negedge clock);
    force_fin = 1'b1;
    @(negedge clock);
    @(negedge clock);
    force_fin = 1'b0;
    check("glitch_still_busy", 64'({busy, rsp_valid}), 64'(2'b10));
    expect_rsp("glitch", 32'd30, 1'b0, 2'b00, 8);
    consume("glitch", 0);

    // Reset during WAIT aborts the op without a response
    alu_delay = 0;
    send(4'h8, 32'd1, 32'd1);
    n = 0;
    while (!alu_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_ctrl", 64'({req_ready, rsp_valid, alu_start, busy}), 64'(4'b1000));
    check("midreset_operands", {alu_a, alu_b}, 64'd0);
    check("midreset_opcode", 64'(alu_opcode), 64'd0);
    seen = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    check("midreset_no_response", 64'(seen), 64'd0);

    // Randomized requests against the rule-based model
    for (int i = 0; i < 25; i++) begin
      rv.op = 4'($urandom_range(0, 15));
      rv.a = $urandom;
      rv.b = $urandom;
      rv.delay = $urandom_range(0, 9);
      rv.status = model_status(rv.op, rv.delay);
      r = alu_fn(rv.op, rv.a, rv.b);
      rv.c = (rv.status == 2'b00) ? r[WIDTH-1:0] : '0;
      rv.sign = (rv.status == 2'b00) ? r[WIDTH] : 1'b0;
      run_vec($sformatf("rnd%0d", i), rv, $urandom_range(0, 3));
    end

    @(negedge clock);
    check("no_back_to_back_start", 64'(b2b), 64'd0);
    check("operands_stable_while_busy", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_requester.md
Name: alu_requester

Overview:
- Initiator side of the ALU start/finish handshake.
- Accepts operation requests (opcode, A, B) over valid/ready and drives operands, opcode and a one-cycle start pulse into the ALU.
- Waits for the ALU's finish, then returns C, sign and a status over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU. It adds illegal-opcode rejection and timeout protection.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned (must be > FINISH_BLANK).
- FINISH_BLANK, 2, number of initial WAIT cycles during which alu_finish is ignored; this masks stale finish from the ALU's registered start path.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  requester can accept a request.
- req_opcode  in  4  ALU opcode: 0000-0111 logic, 1000-1011 add/sub variants.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_c  out  WIDTH  result.
- rsp_sign  out  1  result sign from ALU.
- rsp_status  out  2  00 ok, 01 illegal opcode, 10 timeout.
- alu_a  out  WIDTH  operand A to ALU.
- alu_b  out  WIDTH  operand B to ALU.
- alu_opcode  out  4  opcode to ALU.
- alu_start  out  1  start pulse to ALU.
- alu_finish  in  1  ALU finish.
- alu_c  in  WIDTH  ALU result.
- alu_sign  in  1  ALU sign.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs, latched operands/opcode and counter go to 0, except req_ready=1. Reset overrides any in-flight operation; no response is produced for the aborted op.
- alu_a, alu_b and alu_opcode are driven from the latch registers only. They stay constant from acceptance until return to IDLE, because the ALU samples opcode every cycle.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch opcode/A/B.
  - If opcode >= 1100: go to RESP with rsp_status=01, rsp_c=0, rsp_sign=0. No alu_start is issued.
  - Otherwise go to QUIET.
- QUIET:
  - Stay while alu_finish=1, since the previous op's finish may still be high.
  - When alu_finish=0, go to ISSUE.
  - The timeout counter runs in QUIET too.
- ISSUE: alu_start=1 for exactly this one cycle; go to WAIT; counter keeps running.
- WAIT:
  - alu_start=0; counter increments each cycle.
  - alu_finish is ignored while the WAIT cycle index < FINISH_BLANK.
  - After blanking, alu_finish=1 captures alu_c→rsp_c and alu_sign→rsp_sign, sets rsp_status=00, and goes to RESP.
  - If the counter reaches TIMEOUT with no qualified finish: go to RESP, rsp_status=10, rsp_c=0, rsp_sign=0.
  - Qualified finish and timeout in the same cycle: finish wins, status 00.
- RESP:
  - rsp_valid=1; rsp_c/sign/status are held stable until rsp_ready=1.
  - The cycle rsp_valid&rsp_ready is seen, go to IDLE, clear rsp_valid and counter.
  - req_ready=0 throughout.
- Counter: cleared on entry to QUIET, saturates at TIMEOUT, width clog2(TIMEOUT+1).
- Minimum latency, with the ALU finishing on the first qualified WAIT cycle: accept at T, QUIET at T+1, ISSUE at T+2, WAIT at T+3 … T+2+FINISH_BLANK, finish sampled at T+3+FINISH_BLANK, rsp_valid at T+4+FINISH_BLANK.
- Exactly one alu_start pulse per legal request; never back-to-back pulses; never a pulse while alu_finish=1.
- Requests arriving while not in IDLE are not accepted (req_ready=0); the requester holds them.

Test Plan:
- Logic op: opcode=0010, A=0xF0F0_0000, B=0xFF00_FF00, ALU model finishes 3 cycles after start -> single alu_start pulse; rsp_c=0xF000_0000, rsp_sign=0, rsp_status=00; alu_opcode stable at 0010 throughout.
- Illegal opcode: opcode=1100, A=1, B=2 -> rsp_valid one cycle after accept, rsp_status=01, rsp_c=0; alu_start never asserts.
- Timeout: ALU model never finishes, TIMEOUT=64 -> rsp_status=10, rsp_c=0, exactly one alu_start, busy until the response is consumed; then an opcode=1000 request with A=5, B=7 completes with rsp_c=12, status 00.
- Stale finish: alu_finish held 1 at acceptance for 5 cycles -> no alu_start until one cycle after alu_finish falls. Separately, a finish pulse inside the FINISH_BLANK window is ignored and the real later finish is captured.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_c/sign/status unchanged, req_ready=0, a pending req_valid is not accepted; accepted on the cycle after rsp_ready handshake.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next cycle state IDLE, req_ready=1, rsp_valid=0, alu_start=0, alu_a/b/opcode=0; no response emitted for the aborted op.
